// File: rtl/tdl_pkg.sv
// Shared definitions for tapped-delay-line TDC channels: sequencer states and
// width helpers used by the measurement controller and the TDL wrapper.
package tdl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    RESULT,
    CLEAR
  } tdl_state_e;

  // Bits needed to hold a tap count 0..taps.
  function automatic int unsigned fine_width(input int unsigned taps);
    return $clog2(taps + 1);
  endfunction

  // Bits needed to hold a counter value 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tdl_therm2bin.sv
// Combinational thermometer-to-binary converter; counts ones so capture
// bubbles in the tap row do not corrupt the fine code.
module tdl_therm2bin
  import tdl_pkg::*;
#(
  parameter  int unsigned TAPS   = 4,
  localparam int unsigned FINE_W = fine_width(TAPS)
) (
  input  logic [TAPS-1:0]   therm,
  output logic [FINE_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      count = count + FINE_W'(therm[i]);
    end
  end

endmodule

// File: rtl/tdl_measure_ctrl.sv
// Sequencer for one TDL channel: arms the line, counts coarse cycles until a
// hit, encodes fine+coarse into a result word, then flushes the line.
module tdl_measure_ctrl
  import tdl_pkg::*;
#(
  parameter  int unsigned TAPS       = 4,
  parameter  int unsigned COARSE_W   = 16,
  parameter  int unsigned ARM_CYCLES = 2,
  parameter  int unsigned CLR_CYCLES = 2,
  localparam int unsigned FINE_W     = fine_width(TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TAPS-1:0]     tap_in,
  output logic                tdl_en,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [FINE_W-1:0]   res_fine,
  output logic [COARSE_W-1:0] res_coarse,
  output logic                res_timeout,
  output logic                res_early
);

  localparam int unsigned PH_W =
    cnt_width((ARM_CYCLES > CLR_CYCLES) ? ARM_CYCLES : CLR_CYCLES);
  localparam logic [PH_W-1:0]     ARM_LAST   = PH_W'(ARM_CYCLES - 1);
  localparam logic [PH_W-1:0]     CLR_LAST   = PH_W'(CLR_CYCLES - 1);
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;

  tdl_state_e          state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic [COARSE_W-1:0] rcoarse_q, rcoarse_d;
  logic                timeout_q, timeout_d;
  logic                early_q, early_d;
  logic [FINE_W-1:0]   tap_count;
  logic                hit;

  tdl_therm2bin #(
    .TAPS(TAPS)
  ) u_therm2bin (
    .therm(tap_in),
    .count(tap_count)
  );

  assign hit = |tap_in;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    rcoarse_d = rcoarse_q;
    timeout_d = timeout_q;
    early_d   = early_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          phase_d = '0;
        end
      end
      ARM: begin
        if (hit) begin
          state_d   = RESULT;
          fine_d    = '0;
          rcoarse_d = '0;
          timeout_d = 1'b0;
          early_d   = 1'b1;
        end else if (phase_q == ARM_LAST) begin
          state_d  = WAIT;
          coarse_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      WAIT: begin
        // A hit in the saturated cycle still wins over the timeout.
        if (hit) begin
          state_d   = RESULT;
          fine_d    = tap_count;
          rcoarse_d = coarse_q;
          timeout_d = 1'b0;
          early_d   = 1'b0;
        end else if (coarse_q == COARSE_MAX) begin
          state_d   = RESULT;
          fine_d    = '0;
          rcoarse_d = COARSE_MAX;
          timeout_d = 1'b1;
          early_d   = 1'b0;
        end else begin
          coarse_d = coarse_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = CLEAR;
          phase_d = '0;
        end
      end
      CLEAR: begin
        if (phase_q == CLR_LAST) begin
          if (!hit) state_d = IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      coarse_q  <= '0;
      fine_q    <= '0;
      rcoarse_q <= '0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      rcoarse_q <= rcoarse_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
    end
  end

  assign tdl_en      = (state_q == ARM) || (state_q == WAIT);
  assign busy        = (state_q != IDLE);
  assign res_valid   = (state_q == RESULT);
  assign res_fine    = fine_q;
  assign res_coarse  = rcoarse_q;
  assign res_timeout = timeout_q;
  assign res_early   = early_q;

endmodule

// File: tb/tb_tdl_measure_ctrl.sv
// Self-checking bench for tdl_measure_ctrl: directed scenarios plus randomized
// measurements checked against a transaction-level expectation.
module tb_tdl_measure_ctrl;

  localparam int unsigned TAPS       = 4;
  localparam int unsigned COARSE_W   = 4;
  localparam int unsigned ARM_CYCLES = 2;
  localparam int unsigned CLR_CYCLES = 2;
  localparam int unsigned FINE_W     = $clog2(TAPS + 1);
  localparam int          CMAX       = (1 << COARSE_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [TAPS-1:0]     tap_in;
  logic                tdl_en;
  logic                busy;
  logic                res_valid;
  logic                res_ready;
  logic [FINE_W-1:0]   res_fine;
  logic [COARSE_W-1:0] res_coarse;
  logic                res_timeout;
  logic                res_early;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tdl_measure_ctrl #(
    .TAPS(TAPS),
    .COARSE_W(COARSE_W),
    .ARM_CYCLES(ARM_CYCLES),
    .CLR_CYCLES(CLR_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tap_in(tap_in),
    .tdl_en(tdl_en),
    .busy(busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_fine(res_fine),
    .res_coarse(res_coarse),
    .res_timeout(res_timeout),
    .res_early(res_early)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string pfx, input int fine, input int coarse,
                              input bit to, input bit early);
    chk({pfx, "_valid"}, res_valid, 1);
    chk({pfx, "_en"}, tdl_en, 0);
    chk({pfx, "_busy"}, busy, 1);
    chk({pfx, "_fine"}, res_fine, fine);
    chk({pfx, "_coarse"}, res_coarse, coarse);
    chk({pfx, "_timeout"}, res_timeout, to);
    chk({pfx, "_early"}, res_early, early);
  endtask

  // One full measurement. early_at<0: no early trigger; abort_at>=0: rst in
  // that WAIT cycle; hit_delay>CMAX means the line never fires.
  task automatic run_meas(input int early_at, input logic [TAPS-1:0] early_code,
                          input int hit_delay, input logic [TAPS-1:0] code,
                          input int ready_wait, input int linger,
                          input bit noisy, input int abort_at);
    bit is_early, is_to;
    int exp_fine, exp_coarse, exp_clr, k;
    is_early   = (early_at >= 0);
    is_to      = !is_early && (hit_delay > CMAX);
    exp_fine   = (is_early || is_to) ? 0 : $countones(code);
    exp_coarse = is_early ? 0 : (is_to ? CMAX : hit_delay);
    exp_clr    = ((CLR_CYCLES - 1 > linger) ? CLR_CYCLES - 1 : linger) + 1;

    chk("pre_idle", busy, 0);
    start  = 1'b1;
    tap_in = '0;
    tick();
    start = 1'b0;

    for (int a = 0; a < ARM_CYCLES; a++) begin
      chk("arm_en", tdl_en, 1);
      chk("arm_valid", res_valid, 0);
      if (is_early && a == early_at) begin
        tap_in = early_code;
        tick();
        tap_in = '0;
        break;
      end
      tick();
    end

    if (!is_early) begin
      for (int c = 0; c <= CMAX; c++) begin
        chk("wait_en", tdl_en, 1);
        chk("wait_valid", res_valid, 0);
        if (c == abort_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_en", tdl_en, 0);
          chk("abort_valid", res_valid, 0);
          chk("abort_fine", res_fine, 0);
          chk("abort_coarse", res_coarse, 0);
          chk("abort_flags", {res_timeout, res_early}, 0);
          return;
        end
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c == hit_delay) begin
          tap_in = code;
          tick();
          tap_in = '0;
          break;
        end
        tick();
      end
      start = 1'b0;
    end

    check_result("res", exp_fine, exp_coarse, is_to, is_early);
    for (int w = 0; w < ready_wait; w++) begin
      res_ready = 1'b0;
      start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tap_in    = TAPS'($urandom);
      tick();
      check_result("hold", exp_fine, exp_coarse, is_to, is_early);
    end

    res_ready = 1'b1;
    start     = 1'b0;
    tap_in    = '0;
    tick();
    res_ready = 1'b0;
    chk("xfer_valid", res_valid, 0);
    chk("xfer_busy", busy, 1);
    chk("xfer_en", tdl_en, 0);

    k = 0;
    while (busy === 1'b1 && k < 40) begin
      tap_in = (k < linger) ? TAPS'($urandom_range(1, (1 << TAPS) - 1)) : '0;
      start  = noisy;
      res_ready = 1'($urandom_range(0, 1));
      chk("clr_en", tdl_en, 0);
      chk("clr_valid", res_valid, 0);
      tick();
      k++;
    end
    start     = 1'b0;
    tap_in    = '0;
    res_ready = 1'b0;
    chk("clr_len", k, exp_clr);
    chk("idle_en", tdl_en, 0);
    chk("idle_valid", res_valid, 0);
    tick();
    chk("exit_start_dropped", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    tap_in    = '1;
    res_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_en", tdl_en, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_fine", res_fine, 0);
    chk("rst_coarse", res_coarse, 0);
    chk("rst_flags", {res_timeout, res_early}, 0);
    rst       = 1'b0;
    start     = 1'b0;
    tap_in    = '0;
    res_ready = 1'b0;
    tick();
    chk("idle_hold", busy, 0);

    run_meas(-1, '0, 5, 4'b0011, 10, 0, 0, -1);
    run_meas(-1, '0, 20, 4'b0001, 2, 1, 0, -1);
    run_meas(-1, '0, CMAX, 4'b1111, 0, 0, 0, -1);
    run_meas(0, 4'b0001, 0, '0, 1, 3, 0, -1);
    run_meas(ARM_CYCLES - 1, 4'b0100, 0, '0, 0, 0, 0, -1);
    run_meas(-1, '0, 3, 4'b1011, 3, 2, 1, -1);
    run_meas(-1, '0, 0, 4'b0111, 0, 0, 0, -1);
    run_meas(-1, '0, 8, 4'b0001, 0, 0, 0, 4);
    run_meas(-1, '0, 6, 4'b1110, 1, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      int ea, hd, ab;
      logic [TAPS-1:0] ec, cd;
      ea = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ARM_CYCLES - 1)) : -1;
      ec = TAPS'($urandom_range(1, (1 << TAPS) - 1));
      hd = int'($urandom_range(0, CMAX + 3));
      cd = TAPS'($urandom_range(1, (1 << TAPS) - 1));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_meas(ea, ec, hd, cd, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)), ab);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
